// File: rtl/sisc_pkg.sv
// Shared SISC control definitions: default widths, state and opcode encodings,
// write-back mux selects and the registered control bundle.
package sisc_pkg;

    localparam int unsigned SISC_STAT_W   = 4;
    localparam int unsigned SISC_OPC_W    = 4;
    localparam int unsigned SISC_ALU_OP_W = 2;
    localparam int unsigned SISC_AM_IMM   = 8;
    localparam int unsigned STATE_W       = 4;
    localparam int unsigned WB_SEL_W      = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_START0    = 4'd0,
        ST_START1    = 4'd1,
        ST_FETCH     = 4'd2,
        ST_DECODE    = 4'd3,
        ST_EXECUTE   = 4'd4,
        ST_MEM       = 4'd5,
        ST_WRITEBACK = 4'd6,
        ST_SWAP2     = 4'd7,
        ST_HALT      = 4'd8
    } state_e;

    localparam int unsigned OP_NOOP   = 0;
    localparam int unsigned OP_LOD    = 1;
    localparam int unsigned OP_STR    = 2;
    localparam int unsigned OP_SWP    = 3;
    localparam int unsigned OP_BRA    = 4;
    localparam int unsigned OP_BRR    = 5;
    localparam int unsigned OP_BNE    = 6;
    localparam int unsigned OP_BNR    = 7;
    localparam int unsigned OP_ALU_OP = 8;
    localparam int unsigned OP_HLT    = 15;

    typedef enum logic [WB_SEL_W-1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_SWAP = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic    halted;
        logic    ir_load;
        logic    pc_write;
        logic    pc_sel;
        logic    br_sel;
        logic    rf_we;
        logic    dm_we;
        logic    rb_sel;
        wb_sel_e wb_sel;
    } ctrl_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-field inputs and datapath control outputs of the SISC sequencer.
interface ctrl_seq_if #(
    parameter int unsigned STAT_W   = sisc_pkg::SISC_STAT_W,
    parameter int unsigned OPC_W    = sisc_pkg::SISC_OPC_W,
    parameter int unsigned ALU_OP_W = sisc_pkg::SISC_ALU_OP_W
) ();

    logic [OPC_W-1:0]    opcode;
    logic [STAT_W-1:0]   mm;
    logic [STAT_W-1:0]   stat;
    logic                ir_load;
    logic                pc_write;
    logic                pc_sel;
    logic                br_sel;
    logic                rf_we;
    logic [1:0]          wb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                dm_we;
    logic                rb_sel;
    logic                halted;
    logic [3:0]          state;

    modport master (
        output opcode, mm, stat,
        input  ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, alu_op,
               dm_we, rb_sel, halted, state
    );

    modport slave (
        input  opcode, mm, stat,
        output ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, alu_op,
               dm_we, rb_sel, halted, state
    );

endinterface

// File: rtl/ctrl_seq_br_eval.sv
// Branch resolution: taken flag and relative/absolute target select from
// opcode and the masked status flags.
module br_eval
    import sisc_pkg::*;
#(
    parameter int unsigned OPC_W  = SISC_OPC_W,
    parameter int unsigned STAT_W = SISC_STAT_W
) (
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic [STAT_W-1:0] stat_i,
    input  logic [STAT_W-1:0] mm_i,
    output logic              taken_c_o,
    output logic              rel_c_o
);

    logic hit;

    always_comb begin
        hit       = |(stat_i & mm_i);
        taken_c_o = 1'b0;
        rel_c_o   = 1'b0;
        case (opcode_i)
            OPC_W'(OP_BRA): taken_c_o = hit;
            OPC_W'(OP_BRR): begin
                taken_c_o = hit;
                rel_c_o   = 1'b1;
            end
            OPC_W'(OP_BNE): taken_c_o = ~hit;
            OPC_W'(OP_BNR): begin
                taken_c_o = ~hit;
                rel_c_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle SISC control sequencer with latched HALT. Optional performance
// counters (cyc_cnt, instr_cnt) are built when CTRL_PERF_CNT_EN is defined.
module ctrl_seq
    import sisc_pkg::*;
#(
    parameter int unsigned STAT_W   = SISC_STAT_W,
    parameter int unsigned OPC_W    = SISC_OPC_W,
    parameter int unsigned ALU_OP_W = SISC_ALU_OP_W,
    parameter int unsigned AM_IMM   = SISC_AM_IMM
) (
    input  logic        clk,
    input  logic        rst_f,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt,
`endif
    ctrl_seq_if.slave   bus
);

    state_e              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
    logic                br_taken, br_rel;
    logic                is_lod, is_str, is_swp, is_alu, is_hlt;

    br_eval #(.OPC_W(OPC_W), .STAT_W(STAT_W)) u_br_eval (
        .opcode_i  (bus.opcode),
        .stat_i    (bus.stat),
        .mm_i      (bus.mm),
        .taken_c_o (br_taken),
        .rel_c_o   (br_rel)
    );

    assign is_lod = (bus.opcode == OPC_W'(OP_LOD));
    assign is_str = (bus.opcode == OPC_W'(OP_STR));
    assign is_swp = (bus.opcode == OPC_W'(OP_SWP));
    assign is_alu = (bus.opcode == OPC_W'(OP_ALU_OP));
    assign is_hlt = (bus.opcode == OPC_W'(OP_HLT));

    // Next state, then Moore outputs decoded from the state being entered.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = '0;
        alu_op_d = '0;

        case (state_q)
            ST_START0:    state_d = ST_START1;
            ST_START1:    state_d = ST_FETCH;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE:    state_d = is_hlt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_d = ST_MEM;
            ST_MEM:       state_d = ST_WRITEBACK;
            ST_WRITEBACK: state_d = is_swp ? ST_SWAP2 : ST_FETCH;
            ST_SWAP2:     state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_START0;
        endcase

        case (state_d)
            ST_FETCH: begin
                ctrl_d.ir_load  = 1'b1;
                ctrl_d.pc_write = 1'b1;
            end
            ST_EXECUTE: begin
                if (br_taken) begin
                    ctrl_d.pc_write = 1'b1;
                    ctrl_d.pc_sel   = 1'b1;
                    ctrl_d.br_sel   = br_rel;
                end
                if (is_alu) begin
                    alu_op_d = ALU_OP_W'({bus.mm == STAT_W'(AM_IMM), 1'b1});
                end
            end
            ST_MEM: begin
                ctrl_d.dm_we  = is_str;
                ctrl_d.rb_sel = is_str;
            end
            ST_WRITEBACK: begin
                if (is_alu) begin
                    ctrl_d.rf_we  = 1'b1;
                    ctrl_d.wb_sel = WB_ALU;
                end else if (is_lod) begin
                    ctrl_d.rf_we  = 1'b1;
                    ctrl_d.wb_sel = WB_MEM;
                end else if (is_swp) begin
                    ctrl_d.rf_we  = 1'b1;
                    ctrl_d.wb_sel = WB_SWAP;
                    ctrl_d.rb_sel = 1'b1;
                end
            end
            ST_SWAP2: begin
                ctrl_d.rf_we  = 1'b1;
                ctrl_d.wb_sel = WB_SWAP;
            end
            ST_HALT: ctrl_d.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q  <= ST_START0;
            ctrl_q   <= '0;
            alu_op_q <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign bus.ir_load  = ctrl_q.ir_load;
    assign bus.pc_write = ctrl_q.pc_write;
    assign bus.pc_sel   = ctrl_q.pc_sel;
    assign bus.br_sel   = ctrl_q.br_sel;
    assign bus.rf_we    = ctrl_q.rf_we;
    assign bus.wb_sel   = ctrl_q.wb_sel;
    assign bus.alu_op   = alu_op_q;
    assign bus.dm_we    = ctrl_q.dm_we;
    assign bus.rb_sel   = ctrl_q.rb_sel;
    assign bus.halted   = ctrl_q.halted;
    assign bus.state    = 4'(state_q);

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // Cycles are counted while running; instructions retire on return to FETCH.
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != ST_START0 && state_q != ST_HALT) begin
            cyc_cnt_d = cyc_cnt_q + 32'd1;
        end
        if (state_d == ST_FETCH &&
            (state_q == ST_WRITEBACK || state_q == ST_SWAP2)) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            cyc_cnt_q   <= '0;
            instr_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Testbench for ctrl_seq: directed and randomized instructions checked against
// a per-instruction phase model built from the opcode rules.
module tb_ctrl_seq;
    import sisc_pkg::*;

    logic clk   = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    ctrl_seq_if bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, instr_cnt;
    int unsigned m_cyc, m_instr;
`endif

    ctrl_seq dut (
        .clk       (clk),
        .rst_f     (rst_f),
`ifdef CTRL_PERF_CNT_EN
        .cyc_cnt   (cyc_cnt),
        .instr_cnt (instr_cnt),
`endif
        .bus       (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_st = 0;

    logic [11:0] obs_cw;
    assign obs_cw = {bus.halted, bus.ir_load, bus.pc_write, bus.pc_sel, bus.br_sel,
                     bus.rf_we, bus.wb_sel, bus.alu_op, bus.dm_we, bus.rb_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packed control word: {halted, ir_load, pc_write, pc_sel, br_sel, rf_we, wb_sel, alu_op, dm_we, rb_sel}
    function automatic logic [11:0] cw(input logic h, il, pw, ps, bs, rw,
                                       input logic [1:0] wb, ao,
                                       input logic dw, rb);
        return {h, il, pw, ps, bs, rw, wb, ao, dw, rb};
    endfunction

    task automatic step(input int nst, input logic [11:0] ecw, input string tag);
`ifdef CTRL_PERF_CNT_EN
        if (exp_st != 0 && exp_st != 8) m_cyc++;
        if (nst == 2 && (exp_st == 6 || exp_st == 7)) m_instr++;
`endif
        @(posedge clk);
        #1;
        exp_st = nst;
        check({tag, "/state"}, 32'(bus.state), 32'(nst));
        check({tag, "/ctrl"}, 32'(obs_cw), 32'(ecw));
    endtask

    task automatic apply_reset();
        rst_f = 1'b1;
        #1;
        exp_st = 0;
`ifdef CTRL_PERF_CNT_EN
        m_cyc   = 0;
        m_instr = 0;
`endif
        check("rst_async/state", 32'(bus.state), 32'd0);
        check("rst_async/ctrl", 32'(obs_cw), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold/state", 32'(bus.state), 32'd0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_hold/cyc", cyc_cnt, 32'd0);
        check("rst_hold/instr", instr_cnt, 32'd0);
`endif
        rst_f = 1'b0;
        step(1, 12'd0, "start1");
    endtask

    task automatic fetch();
        step(2, cw(0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0), "fetch");
`ifdef CTRL_PERF_CNT_EN
        check("fetch/cyc", cyc_cnt, m_cyc);
        check("fetch/instr", instr_cnt, m_instr);
`endif
    endtask

    // Phases after FETCH; stops after DECODE for HLT (caller handles HALT).
    task automatic body(input logic [3:0] opc, input logic [3:0] mm, input logic [3:0] stat);
        logic hit, taken, rel;
        logic [11:0] ex, mem, wb;
        bus.opcode = opc;
        bus.mm     = mm;
        bus.stat   = stat;
        step(3, 12'd0, "decode");
        if (opc == 4'd15) return;
        hit   = (stat & mm) != 4'd0;
        taken = ((opc == 4'd4 || opc == 4'd5) && hit) ||
                ((opc == 4'd6 || opc == 4'd7) && !hit);
        rel   = (opc == 4'd5 || opc == 4'd7);
        ex    = taken ? cw(0, 0, 1, 1, rel, 0, 2'd0, 2'd0, 0, 0) : 12'd0;
        if (opc == 4'd8) ex = cw(0, 0, 0, 0, 0, 0, 2'd0, {mm == 4'd8, 1'b1}, 0, 0);
        step(4, ex, "execute");
        mem = (opc == 4'd2) ? cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1) : 12'd0;
        step(5, mem, "mem");
        case (opc)
            4'd8:    wb = cw(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0, 0);
            4'd1:    wb = cw(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0);
            4'd3:    wb = cw(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 1);
            default: wb = 12'd0;
        endcase
        step(6, wb, "writeback");
        if (opc == 4'd3) step(7, cw(0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0), "swap2");
    endtask

    task automatic run(input logic [3:0] opc, input logic [3:0] mm, input logic [3:0] stat);
        fetch();
        body(opc, mm, stat);
    endtask

    initial begin
        logic [3:0] r_opc, r_mm;
        bus.opcode = '0;
        bus.mm     = '0;
        bus.stat   = '0;
        #2;
        apply_reset();

        run(4'd0, 4'd0, 4'd0);
        run(4'd0, 4'd0, 4'd0);
        run(4'd0, 4'd0, 4'd0);
`ifdef CTRL_PERF_CNT_EN
        fetch();
        check("perf3/cyc", cyc_cnt, 32'd16);
        check("perf3/instr", instr_cnt, 32'd3);
        body(4'd0, 4'd0, 4'd0);
`endif

        run(4'd8, 4'd0, 4'd0);
        run(4'd8, 4'd8, 4'd0);
        run(4'd4, 4'b0010, 4'b0010);
        run(4'd4, 4'b0010, 4'b0100);
        run(4'd7, 4'b0001, 4'b0000);
        run(4'd3, 4'd0, 4'd0);
        run(4'd2, 4'd3, 4'd0);
        run(4'd1, 4'd0, 4'd0);
        run(4'd11, 4'd8, 4'hF);

        for (int i = 0; i < 80; i++) begin
            r_opc = 4'($urandom_range(0, 14));
            r_mm  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
            run(r_opc, r_mm, 4'($urandom));
        end

        // Abort a store while its memory write is asserted.
        fetch();
        bus.opcode = 4'd2;
        bus.mm     = 4'd0;
        bus.stat   = 4'd0;
        step(3, 12'd0, "str_decode");
        step(4, 12'd0, "str_execute");
        step(5, cw(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 1), "str_mem");
        #2;
        apply_reset();
        run(4'd8, 4'd8, 4'd0);

        run(4'd15, 4'd0, 4'd0);
        for (int i = 0; i < 20; i++) step(8, cw(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0), "halt");
        apply_reset();

        for (int i = 0; i < 10; i++) begin
            r_opc = 4'($urandom_range(0, 14));
            run(r_opc, 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
